// File: rtl/gx_stream_deserializer.sv
// Byte-granular circular buffer between a word-wide upstream read port and a 1..4 byte consumer.
// Optional feature macro GX_DESER_PEEK_EN adds out_peek (deliver without advancing the read pointer).
module gx_stream_deserializer #(
  parameter int IN_BYTES        = 4,
  parameter int DEPTH           = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    in_read,
  input  logic                    in_valid,
  input  logic [8*IN_BYTES-1:0]   in_data,
  input  logic                    out_read,
  input  logic [2:0]              out_bytes,
`ifdef GX_DESER_PEEK_EN
  input  logic                    out_peek,
`endif
  output logic                    out_valid,
  output logic [31:0]             out_data,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [2:0]    outstanding_reg, outstanding_next;
  logic [2:0]    discard_reg, discard_next;
  logic          out_valid_reg;
  logic [31:0]   out_data_reg;
  logic [31:0]   gather;
  logic [7:0]    rd_byte [4];
  logic          peek, bytes_ok, consume, advance, ret, accept;

`ifdef GX_DESER_PEEK_EN
  assign peek = out_peek;
`else
  assign peek = 1'b0;
`endif

  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign bytes_ok = (out_bytes != 3'd0) && (out_bytes <= 3'd4);
  // The cycle presenting out_valid never consumes, so deliveries are at most every other cycle.
  assign consume  = !flush && out_read && bytes_ok && !out_valid_reg && (level >= PW'(out_bytes));
  assign advance  = consume && !peek;
  // ret: a word returning against an issued read; only words not owed to a flush are stored.
  assign ret      = in_valid && (outstanding_reg != 3'd0);
  assign accept   = ret && (discard_reg == 3'd0) && !flush;

  always_comb begin
    in_read = 1'b0;
    if (!reset && !flush && (int'(outstanding_reg) < MAX_OUTSTANDING) &&
        (int'(level) + IN_BYTES * (int'(outstanding_reg) + 1) <= DEPTH))
      in_read = 1'b1;
  end

  always_comb begin
    outstanding_next = outstanding_reg + {2'b00, in_read} - {2'b00, ret};
    discard_next     = discard_reg;
    if (flush)
      discard_next = outstanding_next;
    else if (ret && (discard_reg != 3'd0))
      discard_next = discard_reg - 3'd1;
    wr_ptr_next = accept ? wr_ptr_reg + PW'(IN_BYTES) : wr_ptr_reg;
    if (flush)
      rd_ptr_next = wr_ptr_reg;
    else if (advance)
      rd_ptr_next = rd_ptr_reg + PW'(out_bytes);
    else
      rd_ptr_next = rd_ptr_reg;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
      assign rd_byte[gi] = mem[AW'(rd_ptr_reg[AW-1:0] + AW'(gi))];
      assign gather[31-8*gi -: 8] = (3'(gi) < out_bytes) ? rd_byte[gi] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < IN_BYTES; i++)
        mem[AW'(wr_ptr_reg[AW-1:0] + AW'(i))] <= in_data[8*(IN_BYTES-1-i) +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      out_valid_reg   <= consume;
      if (consume)
        out_data_reg <= gather;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
endmodule

// File: doc/gx_stream_deserializer.md
GX_STREAM_DESERIALIZER -- requirements
Module: gx_stream_deserializer

Interface
REQ-001 Parameter IN_BYTES, default 4, SHALL set the upstream word width in bytes (legal: 4, 8).
REQ-002 Parameter DEPTH, default 16, SHALL set the byte-store depth in bytes (power of 2, at least 2*IN_BYTES).
REQ-003 Parameter MAX_OUTSTANDING, default 2, SHALL set the maximum number of upstream reads issued but not yet returned (1..4).
REQ-004 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port in_read, output, 1: one-cycle pulse requesting one upstream word.
REQ-007 Port in_valid, input, 1: upstream word present on in_data this cycle.
REQ-008 Port in_data, input, 8*IN_BYTES: upstream word, first byte in the MSBs.
REQ-009 Port out_read, input, 1: consumer request, held until out_valid.
REQ-010 Port out_bytes, input, 3: requested byte count, 1..4.
REQ-011 Port out_valid, output, 1: one-cycle pulse; out_data is valid.
REQ-012 Port out_data, output, 32: delivered bytes, left-aligned, unused low bytes zero.
REQ-013 Port flush, input, 1: synchronous discard of all buffered and in-flight data.
REQ-014 Port level, output, log2(DEPTH)+1: bytes currently buffered.

Function
REQ-015 Storage SHALL be a DEPTH-byte circular buffer with read and write pointers of log2(DEPTH)+1 bits; level SHALL equal write pointer minus read pointer.
REQ-016 An in_valid word SHALL be written big-endian in one cycle: in_data MSB byte at the write pointer, the following bytes at consecutive addresses modulo DEPTH.
REQ-017 in_read SHALL pulse when level + IN_BYTES*(outstanding+1) <= DEPTH and outstanding < MAX_OUTSTANDING; back-to-back pulses are legal.
REQ-018 outstanding SHALL increment on in_read and decrement on in_valid; both in one cycle SHALL leave it unchanged.
REQ-019 When out_read=1, out_bytes is 1..4, level >= out_bytes and out_valid=0, the block SHALL consume out_bytes bytes and pulse out_valid in the next cycle, giving a latency of 1.
REQ-020 If level < out_bytes, the block SHALL consume nothing, SHALL NOT pulse out_valid, and SHALL retry every cycle while out_read is held.
REQ-021 out_bytes of 0 or 5..7 SHALL be ignored: no consume, no out_valid.
REQ-022 out_data SHALL hold its value between out_valid pulses.
REQ-023 The block SHALL consume at most once every other cycle; the cycle with out_valid=1 never consumes.
REQ-024 A consume and an in_valid write in the same cycle SHALL both take effect: level' = level + IN_BYTES - out_bytes.
REQ-025 Reads SHALL span the wrap point correctly; for example, at DEPTH=16, read pointer 14 and out_bytes=4, bytes come from addresses 14, 15, 0 and 1.
REQ-026 An in_valid arriving with outstanding=0 SHALL be dropped and SHALL not change level.
REQ-027 flush SHALL set level to 0, cancel any pending consume, set the discard count to outstanding, and suppress in_read in the flush cycle.
REQ-028 While the discard count is non-zero, each in_valid SHALL be dropped and SHALL decrement the discard count.
REQ-029 flush SHALL take priority over a same-cycle in_valid and out_read.

Reset
REQ-030 On reset assertion, with no clock required: pointers=0, level=0, outstanding=0, discard=0, in_read=0, out_valid=0, out_data=0.
REQ-031 Reset asserted mid-transfer SHALL abandon in-flight upstream words; after release, the block SHALL issue in_read on the first clock edge.

Configuration
REQ-032 Macro GX_DESER_PEEK_EN SHALL add input out_peek (1 bit).
REQ-033 With GX_DESER_PEEK_EN defined, out_peek=1 with a qualifying out_read SHALL deliver data per REQ-019 without advancing the read pointer.
REQ-034 Without GX_DESER_PEEK_EN, the out_peek port SHALL not exist and every delivery SHALL consume.

Verification
REQ-035 Defaults; after reset, feed 0x11223344 then 0x55667788; reads of 1, 2, 4 and 1 bytes -> out_data 0x11000000, 0x22330000, 0x44556677, 0x88000000.
REQ-036 Upstream stalled; out_read held with out_bytes=3 and level=2 -> no out_valid; next word 0xAABBCCDD arrives -> out_valid with out_data = first two bytes, then 0xAA.
REQ-037 DEPTH=16; fill to level 16 -> in_read stays low; consume 4 bytes -> in_read pulses within 1 cycle; the 4-byte read across the wrap returns contiguous bytes.
REQ-038 Two reads outstanding, then flush -> level=0; the next two in_valid words are dropped, and the third is stored.
REQ-039 IN_BYTES=8; word 0x0102030405060708 -> two 4-byte reads return 0x01020304 and 0x05060708.
REQ-040 GX_DESER_PEEK_EN; data 0xDEADBEEF; peek of 4 bytes, then read of 4 bytes -> both return 0xDEADBEEF, and level ends at 0.
